// File: rtl/alu_pkg.sv
// Shared definitions for the i16 ALU blocks.
//   WIDTH_DEFAULT : datapath width of the ALU
//   div_state_e   : iterative divider FSM states
//   MIN_NEG       : most negative two's-complement value (0x8000)
//   ALL_ONES      : all-ones word, the divide-by-zero quotient
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

  localparam logic [WIDTH_DEFAULT-1:0] MIN_NEG  = {1'b1, {(WIDTH_DEFAULT - 1){1'b0}}};
  localparam logic [WIDTH_DEFAULT-1:0] ALL_ONES = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
//   rem_i         : partial remainder before the step
//   quo_i         : quotient/dividend shift register before the step
//   divisor_mag_i : divisor magnitude
//   rem_o         : partial remainder after the step
//   quo_o         : shift register after the step (new quotient bit in LSB)
module div_step #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] divisor_mag_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quo_o
);

  localparam logic [Width:0] One = Width'(1) + (Width + 1)'(0);

  logic [Width:0] shifted;
  logic [Width:0] trial;

  always_comb begin
    // {rem, quo} shifted left by one; the extra top bit keeps 2*rem+1 exact.
    shifted = {rem_i, quo_i[Width-1]};
    // Subtract as A + ~B + 1; bit Width is the sign of the trial remainder.
    trial   = shifted + ~{1'b0, divisor_mag_i} + One;
    if (!trial[Width]) begin
      rem_o = trial[Width-1:0];
      quo_o = {quo_i[Width-2:0], 1'b1};
    end else begin
      rem_o = shifted[Width-1:0];
      quo_o = {quo_i[Width-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iter_divider16.sv
// Multi-cycle signed/unsigned restoring divider for the i16 ALU.
// One restoring step per clock on operand magnitudes, sign fixup at the end.
//   clk, rst           : clock, synchronous active-high reset
//   start              : request, accepted only when idle
//   is_signed          : 1 = two's-complement operands
//   dividend, divisor  : operands, captured on accepted start
//   busy               : high while iterating
//   done               : one-cycle pulse, results and flags valid
//   quotient, remainder: results, held until the next operation completes
//   div_by_zero        : divisor was zero
//   overflow           : signed MIN_NEG / -1
// Optional build macro DIV_FASTPATH_EN: divide-by-zero and signed overflow
// skip the iteration and complete one cycle after start.
import alu_pkg::*;

module iter_divider16 #(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_dvd_q, neg_dvd_d;
  logic             neg_dvs_q, neg_dvs_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             in_neg_dvd, in_neg_dvs, in_dbz, in_ovf;

  div_step #(
    .Width(WIDTH)
  ) u_div_step (
    .rem_i        (rem_q),
    .quo_i        (quo_q),
    .divisor_mag_i(dvs_mag_q),
    .rem_o        (step_rem),
    .quo_o        (step_quo)
  );

  always_comb begin
    in_neg_dvd = is_signed & dividend[WIDTH-1];
    in_neg_dvs = is_signed & divisor[WIDTH-1];
    in_dbz     = (divisor == '0);
    in_ovf     = is_signed & (dividend == MIN_NEG) & (divisor == ALL_ONES);

    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_mag_d     = dvs_mag_q;
    dvd_d         = dvd_q;
    neg_dvd_d     = neg_dvd_q;
    neg_dvs_d     = neg_dvs_q;
    dbz_pend_d    = dbz_pend_q;
    ovf_pend_d    = ovf_pend_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d      = dividend;
          neg_dvd_d  = in_neg_dvd;
          neg_dvs_d  = in_neg_dvs;
          dbz_pend_d = in_dbz;
          ovf_pend_d = in_ovf;
          // The shift register starts holding |dividend|; quotient bits enter at the LSB.
          quo_d      = in_neg_dvd ? (~dividend + One) : dividend;
          dvs_mag_d  = in_neg_dvs ? (~divisor + One) : divisor;
          rem_d      = '0;
          cnt_d      = CntInit;
`ifdef DIV_FASTPATH_EN
          if (in_dbz || in_ovf) begin
            state_d = StDone;
            busy_d  = 1'b0;
          end else begin
            state_d = StCalc;
            busy_d  = 1'b1;
          end
`else
          state_d = StCalc;
          busy_d  = 1'b1;
`endif
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = StDone;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d       = StIdle;
        done_d        = 1'b1;
        div_by_zero_d = dbz_pend_q;
        overflow_d    = ovf_pend_q;
        // Special cases are forced so the fast path need not have iterated.
        if (dbz_pend_q) begin
          quotient_d  = ALL_ONES;
          remainder_d = dvd_q;
        end else if (ovf_pend_q) begin
          quotient_d  = MIN_NEG;
          remainder_d = '0;
        end else begin
          quotient_d  = (neg_dvd_q ^ neg_dvs_q) ? (~quo_q + One) : quo_q;
          remainder_d = neg_dvd_q ? (~rem_q + One) : rem_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_mag_q     <= '0;
      dvd_q         <= '0;
      neg_dvd_q     <= 1'b0;
      neg_dvs_q     <= 1'b0;
      dbz_pend_q    <= 1'b0;
      ovf_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_mag_q     <= dvs_mag_d;
      dvd_q         <= dvd_d;
      neg_dvd_q     <= neg_dvd_d;
      neg_dvs_q     <= neg_dvs_d;
      dbz_pend_q    <= dbz_pend_d;
      ovf_pend_q    <= ovf_pend_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_iter_divider16.sv
// Self-checking bench for iter_divider16: directed cases plus random operands
// compared against a plain-arithmetic division model.
module tb_iter_divider16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int fails  = 0;

  logic [15:0] last_q;
  logic        last_ov;

  iter_divider16 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics from plain integer arithmetic.
  task automatic model(input bit sg, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov);
    int sa, sb;
    int unsigned ua, ub;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 16'h0000) begin
      q  = 16'hFFFF;
      r  = a;
      dz = 1'b1;
    end else if (sg && a == 16'h8000 && b == 16'hFFFF) begin
      q  = 16'h8000;
      r  = 16'h0000;
      ov = 1'b1;
    end else if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
    end else begin
      ua = a;
      ub = b;
      q  = 16'(ua / ub);
      r  = 16'(ua % ub);
    end
  endtask

  // Issue one operation; optionally pulse a rogue start at cycle inject_at.
  task automatic run_op(input bit sg, input logic [15:0] a, input logic [15:0] b,
                        input int inject_at, input string tag);
    logic [15:0] eq, er, gq, gr;
    logic        edz, eov, gdz, gov;
    int          exp_lat, exp_busy, lat, ndone, busy_cnt;
    model(sg, a, b, eq, er, edz, eov);
    exp_lat  = 17;
    exp_busy = 16;
`ifdef DIV_FASTPATH_EN
    if (edz || eov) begin
      exp_lat  = 1;
      exp_busy = 0;
    end
`endif
    gq = 'x; gr = 'x; gdz = 'x; gov = 'x;
    @(negedge clk);
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = 16'($urandom);
    divisor   = 16'($urandom);
    is_signed = 1'($urandom);
    busy_cnt  = int'(busy);
    lat       = 0;
    ndone     = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == inject_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n == 8 && exp_lat > 8) begin
        check({tag, " hold_q_busy"}, quotient, last_q);
        check({tag, " hold_ov_busy"}, overflow, last_ov);
      end
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = n;
          gq  = quotient;
          gr  = remainder;
          gdz = div_by_zero;
          gov = overflow;
        end
      end else if (lat == 0) begin
        busy_cnt += int'(busy);
      end
      if (lat != 0 && n >= lat + 2) break;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " done_pulses"}, ndone, 1);
    check({tag, " busy_cycles"}, busy_cnt, exp_busy);
    check({tag, " quotient"}, gq, eq);
    check({tag, " remainder"}, gr, er);
    check({tag, " div_by_zero"}, gdz, edz);
    check({tag, " overflow"}, gov, eov);
    check({tag, " hold_quotient"}, quotient, eq);
    last_q  = eq;
    last_ov = eov;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 16'h0000;
    divisor   = 16'h0000;
    last_q    = 16'h0000;
    last_ov   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset flags", {div_by_zero, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b1, 16'd100, 16'd7, 0, "s100/7");
    run_op(1'b1, 16'hFF9C, 16'd7, 0, "s-100/7");
    run_op(1'b0, 16'hFF9C, 16'd7, 0, "uFF9C/7");
    run_op(1'b1, 16'h1234, 16'h0000, 0, "s_dbz");
    run_op(1'b0, 16'h1234, 16'h0000, 0, "u_dbz");
    run_op(1'b1, 16'h8000, 16'hFFFF, 0, "s_ovf");
    run_op(1'b0, 16'h8000, 16'hFFFF, 0, "u_8000/FFFF");
    run_op(1'b1, 16'h0064, 16'hFFF9, 0, "s100/-7");
    run_op(1'b1, 16'hFF9C, 16'hFFF9, 0, "s-100/-7");
    run_op(1'b0, 16'hFFFF, 16'h0001, 0, "uFFFF/1");
    run_op(1'b1, 16'h8000, 16'hFFFF, 0, "s_ovf2");
    run_op(1'b1, 16'd100, 16'd7, 5, "ignored_start");

    // Reset in the middle of an operation.
    @(negedge clk);
    is_signed = 1'b1;
    dividend  = 16'h8000;
    divisor   = 16'hFFFF;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'd500;
    divisor  = 16'd3;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst flags", {div_by_zero, overflow}, 0);
    begin
      int spurious = 0;
      for (int n = 0; n < 25; n++) begin
        @(posedge clk);
        #1;
        spurious += int'(done);
      end
      check("midrst no_done", spurious, 0);
    end
    last_q  = 16'h0000;
    last_ov = 1'b0;
    run_op(1'b1, 16'd100, 16'd7, 0, "after_rst");

    // Random operands, with occasional zero and overflow divisors.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a, b;
      bit sg;
      a  = 16'($urandom);
      b  = 16'($urandom);
      sg = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0000;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = 16'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(sg, a, b, 0, "random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
